fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters: RESET_PC, 32'h1c000000, first fetch address; FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2); MAX_OUTSTANDING, 2, accepted-but-unanswered requests (1..FIFO_DEPTH).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst_sram_req  output  1  fetch request valid.
REQ-005 inst_sram_wr  output  1  constant 0.
REQ-006 inst_sram_size  output  2  constant 2'd2 (word).
REQ-007 inst_sram_addr  output  32  fetch address, word aligned.
REQ-008 inst_sram_addr_ok  input  1  request accepted this cycle.
REQ-009 inst_sram_data_ok  input  1  in-order response valid this cycle.
REQ-010 inst_sram_rdata  input  32  response instruction word.
REQ-011 redirect_valid  input  1  flush and restart fetch.
REQ-012 redirect_pc  input  32  restart address; bits [1:0] ignored, treated as 0.
REQ-013 out_valid  output  1  buffer head valid.
REQ-014 out_ready  input  1  decode accepts head.
REQ-015 out_pc / out_inst  output  32 each  head PC and instruction.

Function
REQ-016 Request FSM states: IDLE (req=0), REQ (req=1, waiting addr_ok); IDLE->REQ when credit available and no redirect this cycle; REQ->IDLE on addr_ok unless credit remains, then stays in REQ with next address.
REQ-017 Credit: fifo_count + outstanding + (req pending) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
REQ-018 While req=1 and addr_ok=0, addr SHALL NOT change, including across redirect.
REQ-019 On addr_ok: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
REQ-020 On data_ok: outstanding -= 1; if discard_cnt>0, drop response and discard_cnt -= 1; else push {resp_pc, rdata} to buffer and resp_pc += 4.
REQ-021 addr_ok and data_ok in same cycle: outstanding unchanged.
REQ-022 Redirect: buffer flushed (out_valid=0 next cycle); fetch_pc and resp_pc <= redirect_pc; discard_cnt <= outstanding after this cycle's updates, excluding any data_ok dropped this cycle.
REQ-023 Redirect with an unaccepted pending request: request held; its later addr_ok increments discard_cnt as well as outstanding; next request uses redirect_pc.
REQ-024 Redirect wins over same-cycle out pop and same-cycle data_ok push.
REQ-025 out_valid = buffer not empty; pop on out_valid & out_ready; push and pop in one cycle allowed when full.
REQ-026 Push never occurs when full (guaranteed by credit); overflow is an assertion failure.
REQ-027 Minimum latency: data_ok in cycle N -> out_valid in cycle N+1.

Reset
REQ-028 During reset: req=0, out_valid=0, addr=RESET_PC, fetch_pc=resp_pc=RESET_PC, outstanding=discard_cnt=0, buffer empty, FSM=IDLE.
REQ-029 First req=1 in first rising edge after reset deasserts, addr=RESET_PC.
REQ-030 Reset mid-transaction discards all in-flight state; late data_ok after reset are ignored while outstanding=0.

Structure
REQ-031 Shared package cpu_pkg holds RESET_PC default, word-size constant, FSM state enum, and SRAM size encodings.
REQ-032 Buffer is sub-module fetch_fifo (parametrised depth/width sync FIFO with flush); counters and FSM in fetch_unit.

Verification
REQ-033 Reset release, addr_ok=1, data_ok one cycle later, out_ready=1 -> addresses 0x1c000000, 0x1c000004, ...; out_pc matches, in order.
REQ-034 out_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, req deasserts, no overflow; resume -> no loss or duplication.
REQ-035 Two accepted requests outstanding, redirect_pc=0x1c000100 -> both responses dropped; first out_pc=0x1c000100.
REQ-036 req pending with addr_ok=0, redirect -> addr unchanged until addr_ok; that response dropped; next addr=redirect_pc.
REQ-037 redirect_pc=0x1c000203 -> fetch at 0x1c000200; redirect same cycle as data_ok and pop -> buffer empty, response dropped.
REQ-038 Reset asserted with outstanding=2 -> all outputs at reset values immediately; restart from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the instruction fetch front end.
package cpu_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic {S_IDLE, S_REQ} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction SRAM, redirect and decode-side signals of the fetch unit.
interface fetch_unit_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, out_valid, out_pc, out_inst,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, out_valid, out_pc, out_inst,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; push and pop may coincide when full.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic full, do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign do_pop = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= do_push ? wp_q + AW'(1) : wp_q;
            rp_q <= do_pop ? rp_q + AW'(1) : rp_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wp_q] <= wdata_i;
    end
    overflow_a: assert property (@(posedge clk) disable iff (reset) !(push_i && full && !pop_i));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests,
// redirect flush/discard of in-flight responses and an output buffer.
module fetch_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk,
    input logic reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 2;
    fetch_state_e state_q, state_d;
    logic [31:0] addr_q, fetch_pc_q, resp_pc_q, redir_pc;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_d;
    logic [$clog2(FIFO_DEPTH):0] cnt;
    logic stale_q, stale_d;
    logic req, acc, pend, resp, drop, push, pop, credit, issue, empty;
    fetch_entry_t wr_entry, head;
    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
    assign acc = req && bus.inst_sram_addr_ok;
    assign pend = req && !bus.inst_sram_addr_ok;
    assign resp = bus.inst_sram_data_ok && out_q != '0;
    assign drop = resp && disc_q != '0;
    assign push = resp && !drop && !bus.redirect_valid;
    assign pop = !empty && bus.out_ready && !bus.redirect_valid;
    // Credit is judged on next-cycle occupancy so back-to-back fetch keeps flowing.
    assign out_d = out_q + CW'(acc) - CW'(resp);
    assign cnt_d = bus.redirect_valid ? '0 : CW'(cnt) + CW'(push) - CW'(pop);
    assign credit = (cnt_d + out_d < CW'(FIFO_DEPTH)) && (out_d < CW'(MAX_OUTSTANDING));
    assign issue = credit && !bus.redirect_valid && !pend;
    // A request held across a redirect is stale: its response is dropped once accepted.
    assign stale_d = bus.redirect_valid ? pend : stale_q && !acc;
    assign disc_d = bus.redirect_valid ? out_d : disc_q - CW'(drop) + CW'(acc && stale_q);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = (pend || issue) ? S_REQ : S_IDLE;
    end
    always_comb begin
        req = state_q == S_REQ;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q <= '0;
            disc_q <= '0;
            stale_q <= 1'b0;
        end else begin
            addr_q <= issue ? fetch_pc_q : addr_q;
            fetch_pc_q <= bus.redirect_valid ? redir_pc : issue ? fetch_pc_q + WORD_BYTES : fetch_pc_q;
            resp_pc_q <= bus.redirect_valid ? redir_pc : push ? resp_pc_q + WORD_BYTES : resp_pc_q;
            out_q <= out_d;
            disc_q <= disc_d;
            stale_q <= stale_d;
        end
    end
    assign wr_entry = '{pc: resp_pc_q, inst: bus.inst_sram_rdata};
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush_i(bus.redirect_valid),
        .push_i(push),
        .pop_i(pop),
        .wdata_i(wr_entry),
        .rdata_o(head),
        .empty_o(empty),
        .count_o(cnt)
    );
    assign bus.inst_sram_req = req;
    assign bus.inst_sram_wr = 1'b0;
    assign bus.inst_sram_size = SIZE_WORD;
    assign bus.inst_sram_addr = addr_q;
    assign bus.out_valid = !empty;
    assign bus.out_pc = head.pc;
    assign bus.out_inst = head.inst;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and a randomized run checked
// against an instruction-stream model (sequential PCs, restarted by redirects).
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h1c000000;
    localparam int DEPTH = 4;
    localparam int MAXO = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0]  drv;
        logic        req;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[9];
    int total = 0;
    int bad = 0;
    int pops = 0;
    logic [31:0] exp_pc;
    logic [31:0] accq[$];
    logic hold_chk, flush_chk;
    logic [31:0] hold_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0badf00d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_pc = RPC;
        accq.delete();
        hold_chk = 1'b0;
        flush_chk = 1'b0;
    endtask

    // One cycle: check invariants, drive inputs, advance the memory and stream model.
    task automatic step(input logic ao, input logic dv, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic acc;
        if (hold_chk) begin
            chk("hold_req", 32'(bus.inst_sram_req), 32'd1);
            chk("hold_addr", bus.inst_sram_addr, hold_addr);
        end
        if (flush_chk) chk("flush_empty", 32'(bus.out_valid), 32'd0);
        if (bus.inst_sram_req) chk("addr_align", 32'(bus.inst_sram_addr[1:0]), 32'd0);
        chk("wr_size", {29'd0, bus.inst_sram_wr, bus.inst_sram_size}, 32'd2);
        bus.inst_sram_addr_ok = ao;
        bus.inst_sram_data_ok = dv;
        bus.inst_sram_rdata = (dv && accq.size() > 0) ? mem(accq[0]) : 32'hdead0bad;
        bus.out_ready = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        acc = bus.inst_sram_req && ao;
        if (bus.out_valid && rdy && !rv) begin
            chk("out_pc", bus.out_pc, exp_pc);
            chk("out_inst", bus.out_inst, mem(exp_pc));
            exp_pc += 32'd4;
            pops++;
        end
        if (rv) exp_pc = {rpc[31:2], 2'b00};
        hold_chk = bus.inst_sram_req && !ao;
        hold_addr = bus.inst_sram_addr;
        flush_chk = rv;
        @(posedge clk);
        if (dv && accq.size() > 0) void'(accq.pop_front());
        if (acc) accq.push_back(hold_addr);
        chk("outstanding_bound", 32'(accq.size() <= MAXO), 32'd1);
        @(negedge clk);
    endtask

    // Serve memory with decode stalled until the buffer head is valid (bounded).
    task automatic wait_head(input string name, input logic [31:0] pc);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            step(1'b1, accq.size() > 0, 1'b0, 1'b0, 32'd0);
            n++;
        end
        chk(name, bus.out_valid ? bus.out_pc : 32'hffffffff, pc);
    endtask

    initial begin
        int n, p0;
        tbl[0] = '{3'b001, 1'b0, RPC,          1'b0, 32'd0};
        tbl[1] = '{3'b101, 1'b1, RPC,          1'b0, 32'd0};
        tbl[2] = '{3'b111, 1'b1, RPC + 32'd4,  1'b0, 32'd0};
        tbl[3] = '{3'b111, 1'b1, RPC + 32'd8,  1'b1, RPC};
        tbl[4] = '{3'b111, 1'b1, RPC + 32'd12, 1'b1, RPC + 32'd4};
        tbl[5] = '{3'b111, 1'b1, RPC + 32'd16, 1'b1, RPC + 32'd8};
        tbl[6] = '{3'b011, 1'b1, RPC + 32'd20, 1'b1, RPC + 32'd12};
        tbl[7] = '{3'b001, 1'b1, RPC + 32'd20, 1'b1, RPC + 32'd16};
        tbl[8] = '{3'b001, 1'b1, RPC + 32'd20, 1'b0, 32'd0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl%0d_req", i), 32'(bus.inst_sram_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), bus.inst_sram_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_pc", i), bus.out_pc, tbl[i].pc);
            step(tbl[i].drv[2], tbl[i].drv[1], tbl[i].drv[0], 1'b0, 32'd0);
        end

        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, accq.size() > 0, 1'b0, 1'b0, 32'd0);
        chk("full_req_low", 32'(bus.inst_sram_req), 32'd0);
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_no_outst", accq.size(), 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) n++;
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        chk("buffered", n, DEPTH);
        wait_head("resume_pc", RPC + 32'd16);

        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("two_outst", accq.size(), 32'd2);
        chk("credit_idle", 32'(bus.inst_sram_req), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000100);
        wait_head("redir_first", 32'h1c000100);

        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000300);
        chk("pend_addr", bus.inst_sram_addr, RPC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("next_req", 32'(bus.inst_sram_req), 32'd1);
        chk("next_addr", bus.inst_sram_addr, 32'h1c000300);
        wait_head("pend_first", 32'h1c000300);

        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, accq.size() > 0, 1'b1, 1'b0, 32'd0);
        chk("pre_redir_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_redir_resp", 32'(accq.size() > 0), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000203);
        wait_head("align_first", 32'h1c000200);

        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("rst_outst", accq.size(), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("rst_req", 32'(bus.inst_sram_req), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_addr", bus.inst_sram_addr, RPC);
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("late_ignored", 32'(bus.out_valid), 32'd0);
        wait_head("rst_restart", RPC);

        do_reset();
        p0 = pops;
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 3) != 0, accq.size() > 0 && $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                 RPC + 32'($urandom_range(0, 4095)));
        chk("progress", 32'(pops - p0 > 200), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
